// File: rtl/fifo_pop_serializer.sv
// fifo_pop_serializer
//
// Drains W-bit entries from a FIFO pop/empty interface and emits each one as
// R = W/OUT_W narrower beats on a valid/accept link, marking the final beat.
// The next entry is popped on the same cycle the previous entry's last beat
// is accepted, so back-to-back entries stream with no bubble.
//
// Parameters:
//   W      FIFO entry width (bits), default 32
//   OUT_W  output beat width (bits), default 8; W % OUT_W == 0, W/OUT_W >= 2
//
// Ports:
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   fifo_empty_r   FIFO registered empty flag
//   fifo_pop_data  FIFO head entry (valid while fifo_empty_r=0)
//   fifo_pop       pop strobe to the FIFO (combinational)
//   flush          drop the held entry and return to IDLE, no pop this cycle
//   out_vld        beat valid
//   out_data       current beat
//   out_last       current beat is the final beat of its entry
//   out_accept     consumer takes the beat when out_vld=1
//
// Build option:
//   LIBV_FIFO_POP_SERIALIZER_MSB_FIRST_EN  defined: most significant slice
//   first; undefined (default): least significant slice first.

module fifo_pop_serializer #(
   parameter int W     = 32,
   parameter int OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fifo_empty_r,
   input  logic [W-1:0]     fifo_pop_data,
   output logic             fifo_pop,
   input  logic             flush,
   output logic             out_vld,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   input  logic             out_accept
);

   localparam int R     = W / OUT_W;
   localparam int IDX_W = (R > 1) ? $clog2(R) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t           st_r,   st_nxt;
   logic [IDX_W-1:0] idx_r,  idx_nxt;
   logic [W-1:0]     hold_r, hold_nxt;

   logic beat_adv;
   logic word_done;

   assign out_vld   = (st_r == BUSY);
   assign out_last  = out_vld & (idx_r == LAST_IDX);
   assign beat_adv  = out_vld & out_accept;
   assign word_done = beat_adv & (idx_r == LAST_IDX);

   // rst gating keeps the strobe low even if reset lands while BUSY.
   assign fifo_pop = ~rst & ~flush & ~fifo_empty_r & ((st_r == IDLE) | word_done);

   // Beat select as an explicit mux over the R slices.
   always_comb begin
      out_data = '0;
      for (int i = 0; i < R; i++) begin
         if (idx_r == IDX_W'(i)) begin
`ifdef LIBV_FIFO_POP_SERIALIZER_MSB_FIRST_EN
            out_data = hold_r[(R-1-i)*OUT_W +: OUT_W];
`else
            out_data = hold_r[i*OUT_W +: OUT_W];
`endif
         end
      end
   end

   always_comb begin
      st_nxt   = st_r;
      idx_nxt  = idx_r;
      hold_nxt = hold_r;
      if (flush) begin
         // Held data is left in place; only the control returns to IDLE.
         st_nxt  = IDLE;
         idx_nxt = '0;
      end else if (fifo_pop) begin
         hold_nxt = fifo_pop_data;
         st_nxt   = BUSY;
         idx_nxt  = '0;
      end else if (word_done) begin
         st_nxt  = IDLE;
         idx_nxt = '0;
      end else if (beat_adv) begin
         idx_nxt = idx_r + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_r   <= IDLE;
         idx_r  <= '0;
         hold_r <= '0;
      end else begin
         st_r   <= st_nxt;
         idx_r  <= idx_nxt;
         hold_r <= hold_nxt;
      end
   end

endmodule

// File: doc/fifo_pop_serializer.md
# fifo_pop_serializer

Downstream drain stage for the team's basic FIFO. It pops W-bit entries from the FIFO's pop/empty interface, holds each entry in a local register, and emits it as W/OUT_W narrower beats on a valid/accept output interface, marking the final beat of each entry. Word-to-word transitions have zero bubbles, so the output link runs at full rate while the FIFO is non-empty.

## Interface
- W, default 32: FIFO entry width (bits).
- OUT_W, default 8: output beat width (bits). W % OUT_W == 0 is required, and R = W/OUT_W must be ≥ 2.
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- fifo_empty_r, input, 1: FIFO registered empty flag.
- fifo_pop_data, input, W: FIFO head entry; combinational from the FIFO read pointer and valid whenever fifo_empty_r=0.
- fifo_pop, output, 1: pop strobe to the FIFO.
- flush, input, 1: discard the held entry and return to IDLE.
- out_vld, output, 1: beat valid.
- out_data, output, OUT_W: current beat.
- out_last, output, 1: current beat is beat R-1 of its entry.
- out_accept, input, 1: consumer takes the beat this cycle when out_vld=1.

## Operation
- State register st_r has two states:
  - IDLE: no entry held.
  - BUSY: an entry is held in hold_r[W-1:0].
- Beat index idx_r is $clog2(R) bits wide and runs 0..R-1.
- out_vld = (st_r==BUSY).
- out_last = out_vld & (idx_r==R-1).
- out_data = hold_r[idx_r*OUT_W +: OUT_W] (LSB-first; see Configuration).
- beat_adv = out_vld & out_accept.
- word_done = beat_adv & (idx_r==R-1).
- fifo_pop = ~flush & ~fifo_empty_r & ((st_r==IDLE) | word_done).
- Transitions, evaluated in priority order:
  - rst: st_r=IDLE, idx_r=0, hold_r=0.
  - flush: st_r=IDLE, idx_r=0. hold_r is unchanged. No pop occurs in the flush cycle.
  - fifo_pop: hold_r=fifo_pop_data, st_r=BUSY, idx_r=0.
  - word_done without a pop: st_r=IDLE, idx_r=0.
  - beat_adv otherwise: idx_r=idx_r+1.
  - Otherwise: hold all state.
- Backpressure: while out_vld=1 and out_accept=0, out_data, out_last, idx_r and hold_r are stable.
- out_accept is ignored while out_vld=0.
- The block never pops while it holds an entry that still has unaccepted beats.
- The block never pops when fifo_empty_r=1.

## Timing
- Reset values: out_vld=0, out_last=0, out_data=0, fifo_pop=0 (fifo_pop is combinational; it is 0 during reset because st_r=IDLE and a pop requires fifo_empty_r=0, and it is gated to 0 by rst).
- Latency: an entry popped in cycle t presents beat 0 in cycle t+1. With continuous accept, the last beat appears in cycle t+R.
- Throughput: one beat per cycle. The next entry's pop coincides with the previous entry's last accepted beat, so beat 0 of the next entry follows with no gap.
- Empty FIFO at word_done: the block goes to IDLE. out_vld=0 from the next cycle until the first cycle after a pop.
- The FIFO push-to-non-empty delay is owned by the FIFO. This block reacts to fifo_empty_r=0 in the same cycle.
- Flush concurrent with out_accept on the last beat: the beat is consumed and the block still goes to IDLE with no pop.
- Reset mid-entry: the remaining beats are lost and the outputs return to their reset values on the next cycle.

## Configuration
- Macro LIBV_FIFO_POP_SERIALIZER_MSB_FIRST_EN controls beat order.
  - Defined: out_data = hold_r[(R-1-idx_r)*OUT_W +: OUT_W], so the most significant slice is emitted first.
  - Undefined (default): LSB-first as above.
- All handshake, last-beat and timing behaviour is identical in both builds.

## Test plan
All scenarios use W=32, OUT_W=8, R=4.
- Reset: hold rst=1 for 2 cycles with fifo_empty_r=0 → fifo_pop=0, out_vld=0, out_last=0, out_data=0x00 throughout.
- Single entry 0xAABBCCDD, out_accept=1: fifo_pop=1 in cycle t. Cycles t+1..t+4 show out_data=DD,CC,BB,AA with out_last=1 only at t+4. FIFO then empty → out_vld=0 at t+5.
- Two back-to-back entries 0x03020100 and 0x07060504, out_accept=1: 8 consecutive beats 00..07. The second fifo_pop is asserted in the same cycle as beat 03 (out_last=1).
- Backpressure: out_accept=0 for 3 cycles while beat 1 (CC) is shown → out_data=CC, out_vld=1, out_last=0 stable. On release, BB follows in the next cycle.
- Flush: assert flush while beat 2 (BB) is shown → fifo_pop=0 in that cycle and out_vld=0 in the next. The following entry 0x11223344 starts at beat 44.
- MSB-first build: entry 0xAABBCCDD → beats AA,BB,CC,DD, with out_last on DD.
